// File: rtl/fp_pkg.sv
// Shared fixed-point helpers for the fp_* arithmetic library: Q-format limits,
// rounding/saturation mode encodings and the accumulator width legality rule.
package fp_pkg;

  localparam int unsigned RND_TRUNC   = 0;
  localparam int unsigned RND_HALF_UP = 1;
  localparam int unsigned SAT_WRAP    = 0;
  localparam int unsigned SAT_CLAMP   = 1;

  // Largest value representable in a W-bit signed word.
  function automatic logic signed [63:0] sat_max(input int unsigned w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  // Smallest value representable in a W-bit signed word.
  function automatic logic signed [63:0] sat_min(input int unsigned w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  // Accumulator must hold n_terms full-width products without wrapping.
  function automatic bit acc_width_ok(input int unsigned w_acc,
                                      input int unsigned w_in,
                                      input int unsigned n_terms);
    return w_acc >= 2 * w_in + $clog2(n_terms);
  endfunction

endpackage

// File: rtl/fp_round_sat.sv
// Combinational shift/round/range-check from a wide signed accumulator down to
// a W_OUT-bit output word; flags always describe the pre-clamp value.
module fp_round_sat
  import fp_pkg::*;
#(
  parameter int unsigned W_ACC = 40,
  parameter int unsigned W_OUT = 16,
  parameter int unsigned SHIFT = 14,
  parameter int unsigned ROUND = RND_HALF_UP,
  parameter int unsigned SAT   = SAT_CLAMP
) (
  input  logic signed [W_ACC-1:0] acc,
  output logic        [W_OUT-1:0] result_c,
  output logic                    overflow_c,
  output logic                    underflow_c
);

  // One guard bit so the rounding increment can never wrap the accumulator.
  localparam int unsigned W_X = W_ACC + 1;

  localparam logic signed [W_X-1:0] RND_ADD =
    (ROUND == RND_HALF_UP && SHIFT > 0) ?
      W_X'(64'sd1 <<< (SHIFT > 0 ? SHIFT - 1 : 0)) : W_X'(64'sd0);
  localparam logic signed [W_X-1:0] MAX_X = W_X'(sat_max(W_OUT));
  localparam logic signed [W_X-1:0] MIN_X = W_X'(sat_min(W_OUT));
  localparam logic [W_OUT-1:0]      MAX_O = W_OUT'(sat_max(W_OUT));
  localparam logic [W_OUT-1:0]      MIN_O = W_OUT'(sat_min(W_OUT));

  logic signed [W_X-1:0] rnd_x;
  logic signed [W_X-1:0] shf_x;

  always_comb begin
    rnd_x       = W_X'(acc) + RND_ADD;
    shf_x       = rnd_x >>> SHIFT;
    overflow_c  = shf_x > MAX_X;
    underflow_c = shf_x < MIN_X;
    result_c    = shf_x[W_OUT-1:0];
    if (SAT == SAT_CLAMP) begin
      if (overflow_c) begin
        result_c = MAX_O;
      end else if (underflow_c) begin
        result_c = MIN_O;
      end
    end
  end

endmodule

// File: rtl/fp_mac.sv
// Pipelined signed fixed-point dot-product MAC with valid/ready flow control:
// multiply, accumulate N_TERMS products, round/saturate, register the result.
module fp_mac
  import fp_pkg::*;
#(
  parameter int unsigned W_in    = 16,
  parameter int unsigned W_in_F  = 14,
  parameter int unsigned W_out   = 16,
  parameter int unsigned W_out_F = 14,
  parameter int unsigned N_TERMS = 4,
  parameter int unsigned W_acc   = 40,
  parameter int unsigned ROUND   = 1,
  parameter int unsigned SAT     = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [W_in-1:0]  a,
  input  logic signed [W_in-1:0]  b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [W_out-1:0] result,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int unsigned W_P   = 2 * W_in;
  localparam int unsigned SHIFT = 2 * W_in_F - W_out_F;
  localparam int unsigned W_CNT = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
  localparam logic [W_CNT-1:0] LAST = W_CNT'(N_TERMS - 1);

  if (!acc_width_ok(W_acc, W_in, N_TERMS)) begin : g_bad_acc
    $error("fp_mac: W_acc too narrow for W_in and N_TERMS");
  end
  if (W_out_F > 2 * W_in_F) begin : g_bad_frac
    $error("fp_mac: W_out_F must not exceed 2*W_in_F");
  end
  if (N_TERMS < 1) begin : g_bad_terms
    $error("fp_mac: N_TERMS must be at least 1");
  end

  logic                    en_c;
  logic signed [W_P-1:0]   p_q, p_d;
  logic                    v1_q, v1_d;
  logic signed [W_acc-1:0] acc_q, acc_d;
  logic [W_CNT-1:0]        cnt_q, cnt_d;
  logic                    done_q, done_d;
  logic [W_out-1:0]        rs_res_q, rs_res_d;
  logic                    rs_ovf_q, rs_ovf_d;
  logic                    rs_udf_q, rs_udf_d;
  logic                    rs_v_q, rs_v_d;
  logic [W_out-1:0]        result_q, result_d;
  logic                    ovf_q, ovf_d;
  logic                    udf_q, udf_d;
  logic                    out_valid_q, out_valid_d;

  logic [W_out-1:0]        rsat_result_c;
  logic                    rsat_ovf_c;
  logic                    rsat_udf_c;

  fp_round_sat #(
    .W_ACC (W_acc),
    .W_OUT (W_out),
    .SHIFT (SHIFT),
    .ROUND (ROUND),
    .SAT   (SAT)
  ) u_round_sat (
    .acc         (acc_q),
    .result_c    (rsat_result_c),
    .overflow_c  (rsat_ovf_c),
    .underflow_c (rsat_udf_c)
  );

  always_comb begin
    en_c        = !(out_valid_q && !out_ready);
    in_ready    = en_c && !reset;
    p_d         = p_q;
    v1_d        = v1_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    done_d      = done_q;
    rs_res_d    = rs_res_q;
    rs_ovf_d    = rs_ovf_q;
    rs_udf_d    = rs_udf_q;
    rs_v_d      = rs_v_q;
    result_d    = result_q;
    ovf_d       = ovf_q;
    udf_d       = udf_q;
    out_valid_d = out_valid_q;

    // Whole pipeline advances together; a held result freezes every stage.
    if (en_c) begin
      p_d    = W_P'(a) * W_P'(b);
      v1_d   = in_valid;
      done_d = 1'b0;
      if (v1_q) begin
        acc_d  = ((cnt_q == '0) ? W_acc'(0) : acc_q) + W_acc'(p_q);
        cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + W_CNT'(1);
        done_d = (cnt_q == LAST);
      end
      rs_v_d = done_q;
      if (done_q) begin
        rs_res_d = rsat_result_c;
        rs_ovf_d = rsat_ovf_c;
        rs_udf_d = rsat_udf_c;
      end
      out_valid_d = rs_v_q;
      if (rs_v_q) begin
        result_d = rs_res_q;
        ovf_d    = rs_ovf_q;
        udf_d    = rs_udf_q;
      end
    end

    // Abandon the partial sum, including any term accepted this cycle.
    if (flush) begin
      v1_d   = 1'b0;
      acc_d  = '0;
      cnt_d  = '0;
      done_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p_q         <= '0;
      v1_q        <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      rs_res_q    <= '0;
      rs_ovf_q    <= 1'b0;
      rs_udf_q    <= 1'b0;
      rs_v_q      <= 1'b0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      p_q         <= p_d;
      v1_q        <= v1_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      rs_res_q    <= rs_res_d;
      rs_ovf_q    <= rs_ovf_d;
      rs_udf_q    <= rs_udf_d;
      rs_v_q      <= rs_v_d;
      result_q    <= result_d;
      ovf_q       <= ovf_d;
      udf_q       <= udf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign overflow  = ovf_q;
  assign underflow = udf_q;

endmodule

// File: tb/tb_fp_mac.sv
// Bench for fp_mac: three instances (round+clamp, round+wrap, truncate+clamp)
// share one stimulus stream and are checked against an arithmetic dot-product model.
module tb_fp_mac;

  logic               clk = 1'b0;
  logic               reset;
  logic               flush;
  logic               in_valid;
  logic               out_ready;
  logic signed [15:0] a;
  logic signed [15:0] b;

  logic               ir  [3];
  logic               ov  [3];
  logic        [15:0] res [3];
  logic               of  [3];
  logic               uf  [3];

  always #5 clk = ~clk;

  fp_mac #(.ROUND(1), .SAT(1)) u_rs (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]),
    .a(a), .b(b), .out_valid(ov[0]), .out_ready(out_ready), .result(res[0]),
    .overflow(of[0]), .underflow(uf[0]));

  fp_mac #(.ROUND(1), .SAT(0)) u_rw (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]),
    .a(a), .b(b), .out_valid(ov[1]), .out_ready(out_ready), .result(res[1]),
    .overflow(of[1]), .underflow(uf[1]));

  fp_mac #(.ROUND(0), .SAT(1)) u_tr (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir[2]),
    .a(a), .b(b), .out_valid(ov[2]), .out_ready(out_ready), .result(res[2]),
    .overflow(of[2]), .underflow(uf[2]));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bounded wait expired", name);
  endtask

  // Reference: exact integer dot product (units of 2^-28) reduced to Q2.14.
  bit RND [3] = '{1'b1, 1'b1, 1'b0};
  bit SATM[3] = '{1'b1, 1'b0, 1'b1};

  function automatic longint floor_div(input longint x, input longint d);
    longint q;
    q = x / d;
    if ((x % d != 0) && (x < 0)) q = q - 1;
    return q;
  endfunction

  function automatic void expect_of(input longint sum, input bit rnd, input bit sat,
                                    output logic [15:0] r, output logic o, output logic u);
    longint v;
    v = rnd ? floor_div(sum + 64'sd8192, 64'sd16384) : floor_div(sum, 64'sd16384);
    o = (v > 32767);
    u = (v < -32768);
    r = v[15:0];
    if (sat && o) r = 16'h7FFF;
    if (sat && u) r = 16'h8000;
  endfunction

  longint      sums[$];
  int          idx[3];
  longint      part;
  int          nterm;
  logic [15:0] last_res[3];
  logic        stall_prev[3];
  logic [15:0] prev_res[3];
  logic        prev_of[3];
  logic        prev_uf[3];

  initial begin
    part  = 0;
    nterm = 0;
    foreach (idx[i]) begin
      idx[i] = 0;
      stall_prev[i] = 1'b0;
      last_res[i] = 16'h0;
    end
  end

  // Compare process: outputs first (state before the coming edge), then model update.
  always @(negedge clk) begin
    logic [15:0] er;
    logic        eo, eu;
    for (int i = 0; i < 3; i++) begin
      if (!reset && ov[i] === 1'b1) begin
        if (stall_prev[i]) begin
          check($sformatf("hold_res_d%0d", i), 64'(res[i]), 64'(prev_res[i]));
          check($sformatf("hold_ovf_d%0d", i), 64'(of[i]), 64'(prev_of[i]));
          check($sformatf("hold_udf_d%0d", i), 64'(uf[i]), 64'(prev_uf[i]));
        end
        if (out_ready) begin
          if (idx[i] < sums.size()) begin
            expect_of(sums[idx[i]], RND[i], SATM[i], er, eo, eu);
            check($sformatf("result_d%0d_n%0d", i, idx[i]), 64'(res[i]), 64'(er));
            check($sformatf("overflow_d%0d_n%0d", i, idx[i]), 64'(of[i]), 64'(eo));
            check($sformatf("underflow_d%0d_n%0d", i, idx[i]), 64'(uf[i]), 64'(eu));
            last_res[i] = res[i];
            idx[i]++;
          end else begin
            check($sformatf("unexpected_out_valid_d%0d", i), 64'(ov[i]), 64'd0);
          end
        end else begin
          check($sformatf("stall_in_ready_d%0d", i), 64'(ir[i]), 64'd0);
        end
      end
      stall_prev[i] = !reset && (ov[i] === 1'b1) && !out_ready;
      prev_res[i]   = res[i];
      prev_of[i]    = of[i];
      prev_uf[i]    = uf[i];
    end
    if (reset) begin
      sums.delete();
      foreach (idx[i]) idx[i] = 0;
      part  = 0;
      nterm = 0;
    end else if (flush) begin
      part  = 0;
      nterm = 0;
    end else if (in_valid && ir[0] === 1'b1) begin
      part = part + longint'(a) * longint'(b);
      nterm++;
      if (nterm == 4) begin
        sums.push_back(part);
        part  = 0;
        nterm = 0;
      end
    end
  end

  task automatic send(input logic [15:0] av, input logic [15:0] bv, input logic fl);
    int t;
    a = av; b = bv; in_valid = 1'b1; flush = fl; t = 0;
    @(negedge clk);
    while (ir[0] !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) fail_now("send_in_ready");
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic send4(input logic [15:0] av, input logic [15:0] bv);
    for (int k = 0; k < 4; k++) send(av, bv, 1'b0);
  endtask

  // Called #1 after the final accept edge k: result must appear after edge k+3.
  task automatic expect_lat(input string nm, input logic [15:0] e0, input logic [15:0] e1,
                            input logic [15:0] e2, input logic eo, input logic eu);
    logic [15:0] e[3];
    e[0] = e0; e[1] = e1; e[2] = e2;
    for (int c = 1; c <= 2; c++) begin
      @(posedge clk); #1;
      check($sformatf("%s_early_k%0d", nm, c), 64'(ov[0]), 64'd0);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s_valid_d%0d", nm, i), 64'(ov[i]), 64'd1);
      check($sformatf("%s_res_d%0d", nm, i), 64'(res[i]), 64'(e[i]));
      check($sformatf("%s_ovf_d%0d", nm, i), 64'(of[i]), 64'(eo));
      check($sformatf("%s_udf_d%0d", nm, i), 64'(uf[i]), 64'(eu));
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((idx[0] < sums.size() || idx[1] < sums.size() || idx[2] < sums.size()) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) fail_now("drain");
    @(posedge clk); #1;
  endtask

  task automatic expect_quiet(input string nm, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      check($sformatf("%s_c%0d", nm, c), 64'(ov[0] | ov[1] | ov[2]), 64'd0);
    end
  endtask

  initial begin
    logic [15:0] mr;
    logic        mo, mu;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;

    // Pin the model against hand-worked values.
    expect_of(64'sd8192, 1'b1, 1'b1, mr, mo, mu);
    check("model_half_lsb_round", 64'(mr), 64'h0001);
    expect_of(-64'sd8192, 1'b0, 1'b1, mr, mo, mu);
    check("model_neg_half_trunc", 64'(mr), 64'hFFFF);
    expect_of(-64'sd1879048192, 1'b1, 1'b0, mr, mo, mu);
    check("model_wrap_neg7", 64'({mr, mo, mu}), 64'({16'h4000, 1'b0, 1'b1}));

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_valid_d%0d", i), 64'(ov[i]), 64'd0);
      check($sformatf("rst_res_d%0d", i), 64'(res[i]), 64'd0);
      check($sformatf("rst_flags_d%0d", i), 64'({of[i], uf[i]}), 64'd0);
      check($sformatf("rst_in_ready_d%0d", i), 64'(ir[i]), 64'd0);
    end
    reset = 1'b0;
    #1;
    check("idle_in_ready", 64'(ir[0]), 64'd1);

    send4(16'h2000, 16'h2000);
    expect_lat("t_half_sq", 16'h4000, 16'h4000, 16'h4000, 1'b0, 1'b0);
    send4(16'h2000, 16'h4000);
    expect_lat("t_ovf", 16'h7FFF, 16'h8000, 16'h7FFF, 1'b1, 1'b0);
    send4(16'h9000, 16'h4000);
    expect_lat("t_udf", 16'h8000, 16'h4000, 16'h8000, 1'b0, 1'b1);
    send(16'h0001, 16'h2000, 1'b0);
    for (int k = 0; k < 3; k++) send(16'h0000, 16'h0000, 1'b0);
    expect_lat("t_rnd_pos", 16'h0001, 16'h0001, 16'h0000, 1'b0, 1'b0);
    send(16'hFFFF, 16'h2000, 1'b0);
    for (int k = 0; k < 3; k++) send(16'h0000, 16'h0000, 1'b0);
    expect_lat("t_rnd_neg", 16'h0000, 16'h0000, 16'hFFFF, 1'b0, 1'b0);
    drain();

    // Back-to-back blocks with the first result held for 5 cycles.
    out_ready = 1'b0;
    fork
      begin
        send4(16'h2000, 16'h2000);
        send(16'h1000, 16'h3000, 1'b0);
        send(16'hF000, 16'h2000, 1'b0);
        send(16'h0800, 16'h0800, 1'b0);
        send(16'hC000, 16'h0100, 1'b0);
      end
      begin
        int t;
        t = 0;
        while (ov[0] !== 1'b1 && t < 100) begin
          @(negedge clk);
          t++;
        end
        if (t >= 100) fail_now("stall_first_result");
        for (int s = 0; s < 5; s++) begin
          for (int i = 0; i < 3; i++) begin
            check($sformatf("stall_ir_d%0d_s%0d", i, s), 64'(ir[i]), 64'd0);
            check($sformatf("stall_res_d%0d_s%0d", i, s), 64'(res[i]), 64'h4000);
          end
          @(negedge clk);
        end
        out_ready = 1'b1;
      end
    join
    drain();
    for (int i = 0; i < 3; i++)
      check($sformatf("b2b_second_d%0d", i), 64'(last_res[i]), 64'h0400);

    // Flush after two terms (with a discarded accept), then reset mid-block.
    send(16'h1000, 16'h1000, 1'b0);
    send(16'h1000, 16'h1000, 1'b0);
    send(16'h1000, 16'h1000, 1'b1);
    for (int k = 0; k < 3; k++) send(16'h1000, 16'h1000, 1'b0);
    reset = 1'b1; in_valid = 1'b1; a = 16'h7FFF; b = 16'h7FFF;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
        check($sformatf("mid_rst_out_d%0d_c%0d", i, c),
              64'({ov[i], of[i], uf[i], res[i]}), 64'd0);
        check($sformatf("mid_rst_ir_d%0d_c%0d", i, c), 64'(ir[i]), 64'd0);
      end
    end
    reset = 1'b0; in_valid = 1'b0;
    expect_quiet("no_result_after_rst", 6);
    send4(16'h1000, 16'h1000);
    expect_lat("t_after_rst", 16'h1000, 16'h1000, 16'h1000, 1'b0, 1'b0);
    drain();

    // Flush coinciding with the final-term accept wins.
    for (int k = 0; k < 3; k++) send(16'h2000, 16'h2000, 1'b0);
    send(16'h2000, 16'h2000, 1'b1);
    expect_quiet("no_result_flush_last", 6);
    send4(16'h0400, 16'h0400);
    expect_lat("t_after_flush", 16'h0100, 16'h0100, 16'h0100, 1'b0, 1'b0);
    drain();

    for (int i = 0; i < 3; i++)
      check($sformatf("all_results_seen_d%0d", i), 64'(idx[i]), 64'(sums.size()));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
